// File: rtl/acc_readout_pkg.sv
// rtl/acc_readout_pkg.sv - shared types and constants for the carry-save readout
package acc_readout_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W         = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/acc_cpa_cell.sv
// rtl/acc_cpa_cell.sv - bit-serial full adder folding the carry stream into the sum stream
module acc_cpa_cell (
  input  logic clk,
  input  logic rst,
  input  logic beat,
  input  logic first,
  input  logic sin,
  input  logic cin,
  output logic sum_bit,
  output logic ovf
);

  logic       k;
  logic       c_prev;
  logic [1:0] t;

  // Bit 0 ignores leftover carry/k so a restarted frame never inherits old state.
  always_comb begin
    t       = {1'b0, sin} + (first ? 2'b00 : ({1'b0, c_prev} + {1'b0, k}));
    sum_bit = t[0];
    ovf     = t[1] | cin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k      <= 1'b0;
      c_prev <= 1'b0;
    end else if (beat) begin
      k      <= t[1];
      c_prev <= cin;
    end
  end

endmodule

// File: rtl/acc_readout.sv
// rtl/acc_readout.sv - collects a carry-save bit-serial frame and presents the resolved word
module acc_readout
  import acc_readout_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rd,
  input  logic             sin,
  input  logic             cin,
  input  logic             in_valid,
  input  logic             in_first,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_err
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] word_next;
  logic             ovf;
  logic             err;
  logic             accept;
  logic             start;
  logic             take;
  logic             last;
  logic             bit_val;
  logic             ovf_val;

  acc_cpa_cell u_cell (
    .clk     (clk),
    .rst     (rd),
    .beat    (start | take),
    .first   (start),
    .sin     (sin),
    .cin     (cin),
    .sum_bit (bit_val),
    .ovf     (ovf_val)
  );

  always_ff @(posedge clk or posedge rd) begin
    if (rd) state <= IDLE;
    else    state <= state_next;
  end

  // A first-flagged beat always opens a frame; in HOLD it can only be accepted while retiring.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    if (!rd) in_ready = (state == HOLD) ? out_ready : 1'b1;
    accept = in_valid & in_ready;
    start  = accept & in_first;
    take   = accept & ~in_first & (state == COLLECT);
    last   = take & (cnt == CNT_W'(WIDTH - 1));
    case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (last) state_next = HOLD;
      HOLD:    if (out_ready) state_next = start ? COLLECT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    word_next = word;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CNT_W'(i)) word_next[i] = bit_val;
    end
  end

  always_ff @(posedge clk or posedge rd) begin
    if (rd) begin
      cnt  <= '0;
      word <= '0;
      ovf  <= 1'b0;
      err  <= 1'b0;
    end else begin
      err <= start & (state == COLLECT);
      if (start) begin
        cnt  <= CNT_W'(1);
        word <= {{(WIDTH-1){1'b0}}, bit_val};
        ovf  <= 1'b0;
      end else if (take) begin
        cnt  <= cnt + CNT_W'(1);
        word <= word_next;
        if (last) ovf <= ovf_val;
      end
    end
  end

  assign out_word  = word;
  assign out_ovf   = ovf;
  assign out_valid = (state == HOLD);
  assign out_err   = err;

endmodule

// File: tb/tb_acc_readout.sv
// tb/tb_acc_readout.sv - randomized and directed bench for acc_readout at WIDTH=4
module tb_acc_readout;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rd;
  logic         sin;
  logic         cin;
  logic         in_valid;
  logic         in_first;
  logic         in_ready;
  logic [W-1:0] out_word;
  logic         out_ovf;
  logic         out_valid;
  logic         out_ready;
  logic         out_err;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  acc_readout #(.WIDTH(W)) dut (
    .clk       (clk),
    .rd        (rd),
    .sin       (sin),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: frames are gathered as whole sin/cin vectors and resolved arithmetically.
  logic         m_hold = 1'b0;
  logic         m_ovf  = 1'b0;
  logic         m_err  = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_n    = 0;
  int           m_s    = 0;
  int           m_c    = 0;
  int           words  = 0;

  function automatic int resolve(input int s, input int c);
    return s + (c << 1);
  endfunction

  always @(posedge clk) begin
    logic acc;
    int   v;
    if (rd) begin
      m_hold = 1'b0;
      m_n    = 0;
      m_s    = 0;
      m_c    = 0;
      m_err  = 1'b0;
    end else begin
      acc   = in_valid && (!m_hold || out_ready);
      m_err = 1'b0;
      if (m_hold && out_ready) begin
        m_hold = 1'b0;
        words++;
      end
      if (acc && in_first) begin
        if (m_n > 0) m_err = 1'b1;
        m_n = 1;
        m_s = int'(sin);
        m_c = int'(cin);
      end else if (acc && m_n > 0) begin
        m_s = m_s | (int'(sin) << m_n);
        m_c = m_c | (int'(cin) << m_n);
        m_n++;
        if (m_n == W) begin
          v      = resolve(m_s, m_c);
          m_word = v[W-1:0];
          m_ovf  = (v >> W) != 0;
          m_hold = 1'b1;
          m_n    = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (rd) begin
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_err", out_err, 0);
      end else begin
        check("in_ready", in_ready, !m_hold || out_ready);
        check("out_valid", out_valid, m_hold);
        check("out_err", out_err, m_err);
        if (m_hold) begin
          check("out_word", out_word, m_word);
          check("out_ovf", out_ovf, m_ovf);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic s, input logic c);
    in_valid = v;
    in_first = f;
    sin      = s;
    cin      = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic frame(input logic [W-1:0] s, input logic [W-1:0] c);
    for (int i = 0; i < W; i++) drive(1'b1, i == 0, s[i], c[i]);
  endtask

  task automatic lit(input string name, input logic [W-1:0] w, input logic o);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_word"}, out_word, w);
    check({name, "_ovf"}, out_ovf, o);
    check({name, "_model_word"}, m_word, w);
    check({name, "_model_ovf"}, m_ovf, o);
  endtask

  initial begin
    rd        = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    sin       = 1'b0;
    cin       = 1'b0;
    out_ready = 1'b1;
    idle(3);
    started = 1;
    check("reset_word", out_word, 0);
    check("reset_ovf", out_ovf, 0);
    check("reset_valid", out_valid, 0);
    check("reset_ready", in_ready, 0);
    check("reset_err", out_err, 0);
    rd = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);
    idle(2);

    frame(4'b1011, 4'b0001);
    lit("basic_d", 4'hD, 1'b0);
    idle(2);

    frame(4'b1111, 4'b1000);
    lit("ovf_f", 4'hF, 1'b1);
    idle(2);

    out_ready = 1'b0;
    frame(4'b0000, 4'b0111);
    lit("stall_e", 4'hE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_first = 1'b1;
      sin      = 1'b1;
      cin      = 1'b0;
      @(posedge clk);
      #1;
      check("stall_ready", in_ready, 0);
      check("stall_word", out_word, 4'hE);
    end
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("release_valid", out_valid, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    lit("release_5", 4'h5, 1'b0);
    idle(2);

    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("restart_err", out_err, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    check("restart_err_drop", out_err, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    lit("restart_7", 4'h7, 1'b0);
    idle(2);

    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    rd = 1'b1;
    idle(1);
    rd = 1'b0;
    idle(2);
    check("abort_no_valid", out_valid, 0);
    check("abort_no_err", out_err, 0);
    frame(4'b1010, 4'b0101);
    lit("after_abort", 4'h4, 1'b1);
    idle(2);

    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    lit("gap_d", 4'hD, 1'b0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 10) < 7;
      in_first  = (m_n == 0 && !m_hold) ? ($urandom % 2 == 0) : ($urandom % 12 == 0);
      sin       = $urandom % 2;
      cin       = $urandom % 2;
      out_ready = ($urandom % 10) < 7;
      rd        = ($urandom % 400) == 0;
      @(posedge clk);
      #1;
    end
    rd        = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    out_ready = 1'b1;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_readout.md
ACC_READOUT -- requirements
Module: acc_readout

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, number of bit-serial beats per frame (legal range 2..32).
REQ-002 The block SHALL have the following ports, one clock and one asynchronous active-high reset:
- clk  input  1  sole clock; all state changes on the rising edge
- rd  input  1  asynchronous active-high reset
- sin  input  1  serial sum bit from the adder-accumulator, LSB first
- cin  input  1  serial carry bit from the adder-accumulator, same beat as sin
- in_valid  input  1  sin/cin/in_first valid this cycle
- in_first  input  1  marks bit 0 of a frame
- in_ready  output  1  block accepts a beat this cycle
- out_word  output  WIDTH  resolved binary word
- out_ovf  output  1  result exceeded WIDTH bits
- out_valid  output  1  out_word/out_ovf valid
- out_ready  input  1  downstream accepts the word
- out_err  output  1  one-cycle pulse: frame restarted before completion

Function
REQ-003 A beat SHALL be accepted only when in_valid and in_ready are both 1 in the same cycle.
REQ-004 The block SHALL resolve the carry-save stream to binary: value = sum(sin_i * 2^i) + sum(cin_i * 2^(i+1)), i = 0..WIDTH-1.
REQ-005 Per accepted beat i: t = sin_i + cin_(i-1) + k; bit i of the word = t mod 2; k = t div 2; cin_(-1) = 0 and k = 0 at bit 0.
REQ-006 out_ovf SHALL equal (k OR cin_(WIDTH-1)) after beat WIDTH-1.
REQ-007 The state machine SHALL have states IDLE, COLLECT, HOLD.
REQ-008 IDLE: an accepted beat with in_first=1 SHALL be stored as bit 0 and move to COLLECT; accepted beats with in_first=0 SHALL be discarded with no other effect.
REQ-009 COLLECT: a 5-bit beat counter SHALL advance per accepted beat; the WIDTH-th beat SHALL move to HOLD.
REQ-010 out_valid SHALL rise the cycle after the last beat is accepted (latency 1) and stay high, with out_word/out_ovf stable, until out_valid and out_ready are both 1.
REQ-011 in_ready SHALL be 1 in IDLE and COLLECT; in HOLD it SHALL equal out_ready.
REQ-012 HOLD with out_ready=1: the word SHALL be retired; a simultaneously accepted beat with in_first=1 SHALL start the next frame (go to COLLECT); otherwise the next state SHALL be IDLE.
REQ-013 COLLECT: an accepted beat with in_first=1 SHALL discard the partial frame, restart as bit 0, and pulse out_err for exactly one cycle.
REQ-014 Gaps in in_valid within a frame SHALL be allowed and SHALL NOT alter the partial result.
REQ-015 out_word bits not yet written in the current frame SHALL read as 0 when out_valid rises.

Reset
REQ-016 While rd=1: state=IDLE, counter=0, k=0, stored carry=0, out_word=0, out_ovf=0, out_valid=0, out_err=0, in_ready=0.
REQ-017 rd asserted mid-frame or in HOLD SHALL abandon the frame with no out_valid or out_err afterwards; in_ready SHALL return to 1 in the first cycle after rd deasserts.

Structure
REQ-018 Package acc_readout_pkg SHALL hold the state enum (IDLE, COLLECT, HOLD) and the WIDTH default constant.
REQ-019 The per-beat full-adder plus carry/k registers SHALL be a sub-module named acc_cpa_cell; the FSM, counter and output register stay in acc_readout.

Verification (WIDTH=4)
REQ-020 sin=1,1,0,1; cin=1,0,0,0; in_first on beat 0; out_ready=1 -> out_word=4'hD, out_ovf=0, out_valid one cycle after beat 3.
REQ-021 sin=1,1,1,1; cin=0,0,0,1 -> out_word=4'hF, out_ovf=1.
REQ-022 sin=0,0,0,0; cin=1,1,1,0; out_ready=0 for 5 cycles -> out_word=4'hE held stable, in_ready=0 until out_ready=1; an in_first beat presented in the release cycle is accepted.
REQ-023 Two beats, then in_first beat -> out_err pulses one cycle; the next four beats produce one word, no word from the partial frame.
REQ-024 rd pulsed after beat 2, then a full frame -> no output from the aborted frame; the new frame's word is correct.
REQ-025 in_valid dropped for 3 cycles between beats 1 and 2 of the REQ-020 frame -> same result 4'hD, out_ovf=0.
